// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle main controller.
//   - state_t   : controller state encoding (also exported on the debug port)
//   - ALU_*     : 5-bit ALU operation codes driven onto alu_op
//   - OP_*/FUNCT_* : MIPS opcode / function field constants
//   - NPC_*/WD_*/RD_*/SRCA_*/SRCB_* : datapath mux select constants
//   - dec_t     : instruction-class one-hots produced by mc_ctrl_decode
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXE_R    = 4'd2,
    S_EXE_I    = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_LDWB = 4'd6,
    S_MEM_WR   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [4:0] ALU_NOP  = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_ADDU = 5'd2;
  localparam logic [4:0] ALU_SUB  = 5'd3;
  localparam logic [4:0] ALU_SUBU = 5'd4;
  localparam logic [4:0] ALU_AND  = 5'd5;
  localparam logic [4:0] ALU_OR   = 5'd6;
  localparam logic [4:0] ALU_XOR  = 5'd7;
  localparam logic [4:0] ALU_NOR  = 5'd8;
  localparam logic [4:0] ALU_SLT  = 5'd9;
  localparam logic [4:0] ALU_SLTU = 5'd10;
  localparam logic [4:0] ALU_SLL  = 5'd11;
  localparam logic [4:0] ALU_SRL  = 5'd12;
  localparam logic [4:0] ALU_SRA  = 5'd13;
  localparam logic [4:0] ALU_SLLV = 5'd14;
  localparam logic [4:0] ALU_SRLV = 5'd15;
  localparam logic [4:0] ALU_SRAV = 5'd16;
  localparam logic [4:0] ALU_LUI  = 5'd17;
  localparam logic [4:0] ALU_SUBZ = 5'd18;  // rs - 0: drives Gez for bgez/bltz

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_JALR = 6'h09;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  localparam logic [1:0] NPC_ALU    = 2'd0;
  localparam logic [1:0] NPC_ALUOUT = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_RS     = 2'd3;

  localparam logic [1:0] WD_ALUOUT = 2'd0;
  localparam logic [1:0] WD_MDR    = 2'd1;
  localparam logic [1:0] WD_PC     = 2'd2;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_RS    = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;

  localparam logic [1:0] SRCB_RT    = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  typedef struct packed {
    logic       r_alu;
    logic       i_alu;
    logic       lw;
    logic       sw;
    logic       beq;
    logic       bne;
    logic       bgez;
    logic       bltz;
    logic       j;
    logic       jal;
    logic       jr;
    logic       jalr;
    logic       shamt;   // sll/srl/sra take A from the shamt field
    logic       ovf_op;  // add/sub/addi: signed overflow can trap
    logic       zext;    // andi/ori/xori zero-extend the immediate
    logic [4:0] alu_op;  // EXE-state ALU operation
  } dec_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: controller <-> datapath bundle.
//   Datapath -> controller: op_i, funct_i, rt_i (registered IR fields),
//                           zero_i, gez_i, ovf_i (ALU flags, current cycle).
//   Controller -> datapath: write enables, memory strobes, mux selects,
//                           alu_op, trap pulse exc and debug state.
//   modport master: the controller; modport slave: the datapath side.
interface mc_ctrl_if;
  logic [5:0] op_i;
  logic [5:0] funct_i;
  logic [4:0] rt_i;
  logic       zero_i;
  logic       gez_i;
  logic       ovf_i;

  logic       pc_write;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       iord_sel;
  logic [1:0] reg_dst;
  logic [1:0] wd_sel;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_op;
  logic [4:0] alu_op;
  logic [1:0] npc_sel;
  logic       exc;
  logic [3:0] state;

  modport master (
    input  op_i, funct_i, rt_i, zero_i, gez_i, ovf_i,
    output pc_write, ir_write, mem_read, mem_write, reg_write, iord_sel,
           reg_dst, wd_sel, alu_src_a, alu_src_b, ext_op, alu_op, npc_sel,
           exc, state
  );

  modport slave (
    output op_i, funct_i, rt_i, zero_i, gez_i, ovf_i,
    input  pc_write, ir_write, mem_read, mem_write, reg_write, iord_sel,
           reg_dst, wd_sel, alu_src_a, alu_src_b, ext_op, alu_op, npc_sel,
           exc, state
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational instruction classifier.
//   op, funct, rt : IR fields
//   dec           : class one-hots plus the EXE-state ALU operation.
// An encoding not recognised leaves every class bit clear, which the
// controller turns into a trap.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  output dec_t       dec
);

  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_NOP;
    case (op)
      OP_RTYPE: begin
        dec.r_alu = 1'b1;
        case (funct)
          FUNCT_ADD:  begin dec.alu_op = ALU_ADD; dec.ovf_op = 1'b1; end
          FUNCT_ADDU: dec.alu_op = ALU_ADDU;
          FUNCT_SUB:  begin dec.alu_op = ALU_SUB; dec.ovf_op = 1'b1; end
          FUNCT_SUBU: dec.alu_op = ALU_SUBU;
          FUNCT_AND:  dec.alu_op = ALU_AND;
          FUNCT_OR:   dec.alu_op = ALU_OR;
          FUNCT_XOR:  dec.alu_op = ALU_XOR;
          FUNCT_NOR:  dec.alu_op = ALU_NOR;
          FUNCT_SLT:  dec.alu_op = ALU_SLT;
          FUNCT_SLTU: dec.alu_op = ALU_SLTU;
          FUNCT_SLL:  begin dec.alu_op = ALU_SLL; dec.shamt = 1'b1; end
          FUNCT_SRL:  begin dec.alu_op = ALU_SRL; dec.shamt = 1'b1; end
          FUNCT_SRA:  begin dec.alu_op = ALU_SRA; dec.shamt = 1'b1; end
          FUNCT_SLLV: dec.alu_op = ALU_SLLV;
          FUNCT_SRLV: dec.alu_op = ALU_SRLV;
          FUNCT_SRAV: dec.alu_op = ALU_SRAV;
          FUNCT_JR:   begin dec.r_alu = 1'b0; dec.jr = 1'b1; end
          FUNCT_JALR: begin dec.r_alu = 1'b0; dec.jalr = 1'b1; end
          default:    dec.r_alu = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        dec.bgez = (rt == 5'd1);
        dec.bltz = (rt == 5'd0);
      end
      OP_J:     dec.j   = 1'b1;
      OP_JAL:   dec.jal = 1'b1;
      OP_BEQ:   dec.beq = 1'b1;
      OP_BNE:   dec.bne = 1'b1;
      OP_LW:    dec.lw  = 1'b1;
      OP_SW:    dec.sw  = 1'b1;
      OP_ADDI:  begin dec.i_alu = 1'b1; dec.alu_op = ALU_ADD; dec.ovf_op = 1'b1; end
      OP_ADDIU: begin dec.i_alu = 1'b1; dec.alu_op = ALU_ADDU; end
      OP_SLTI:  begin dec.i_alu = 1'b1; dec.alu_op = ALU_SLT;  end
      OP_SLTIU: begin dec.i_alu = 1'b1; dec.alu_op = ALU_SLTU; end
      OP_ANDI:  begin dec.i_alu = 1'b1; dec.alu_op = ALU_AND; dec.zext = 1'b1; end
      OP_ORI:   begin dec.i_alu = 1'b1; dec.alu_op = ALU_OR;  dec.zext = 1'b1; end
      OP_XORI:  begin dec.i_alu = 1'b1; dec.alu_op = ALU_XOR; dec.zext = 1'b1; end
      OP_LUI:   begin dec.i_alu = 1'b1; dec.alu_op = ALU_LUI; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle CPU main controller.
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : mc_ctrl_if.master -- IR fields and ALU flags in; write enables,
//          memory strobes, mux selects, alu_op, exc and debug state out.
// Parameter EXC_ON_OVF: 1 = signed overflow on add/sub/addi suppresses the
// writeback and traps; 0 = writeback proceeds.
// Outputs are decoded from the state register and registered IR fields; the
// only flag-dependent (Mealy) output is pc_write in BRANCH.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter bit EXC_ON_OVF = 1'b1
) (
  input logic      clk,
  input logic      rstn,
  mc_ctrl_if.master bus
);

  state_t state_q;
  logic   ovf_q;
  dec_t   dec;

  mc_ctrl_decode u_decode (
    .op    (bus.op_i),
    .funct (bus.funct_i),
    .rt    (bus.rt_i),
    .dec   (dec)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_FETCH;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          ovf_q   <= 1'b0;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (dec.r_alu)                                 state_q <= S_EXE_R;
          else if (dec.i_alu)                            state_q <= S_EXE_I;
          else if (dec.lw | dec.sw)                      state_q <= S_MEM_ADDR;
          else if (dec.beq | dec.bne | dec.bgez | dec.bltz) state_q <= S_BRANCH;
          else if (dec.j | dec.jal | dec.jr | dec.jalr)  state_q <= S_JUMP;
          else                                           state_q <= S_TRAP;
        end
        S_EXE_R, S_EXE_I: begin
          ovf_q   <= bus.ovf_i & dec.ovf_op & EXC_ON_OVF;
          state_q <= S_ALU_WB;
        end
        S_ALU_WB:   state_q <= ovf_q ? S_TRAP : S_FETCH;
        S_MEM_ADDR: state_q <= dec.lw ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   state_q <= S_MEM_LDWB;
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  logic       pc_write_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c, exc_c;
  logic       iord_c, ext_c;
  logic [1:0] reg_dst_c, wd_c, src_a_c, src_b_c, npc_c;
  logic [4:0] alu_op_c;
  logic       br_taken;

  assign br_taken = (dec.beq  &  bus.zero_i) | (dec.bne  & ~bus.zero_i) |
                    (dec.bgez &  bus.gez_i)  | (dec.bltz & ~bus.gez_i);

  always_comb begin
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    exc_c       = 1'b0;
    iord_c      = 1'b0;
    ext_c       = 1'b0;
    reg_dst_c   = RD_RT;
    wd_c        = WD_ALUOUT;
    src_a_c     = SRCA_PC;
    src_b_c     = SRCB_RT;
    npc_c       = NPC_ALU;
    alu_op_c    = ALU_NOP;
    case (state_q)
      S_FETCH: begin
        pc_write_c = 1'b1;
        ir_write_c = 1'b1;
        mem_read_c = 1'b1;
        src_b_c    = SRCB_FOUR;
        alu_op_c   = ALU_ADDU;
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        src_b_c  = SRCB_IMMSH;
        ext_c    = 1'b1;
        alu_op_c = ALU_ADDU;
      end
      S_EXE_R: begin
        src_a_c  = dec.shamt ? SRCA_SHAMT : SRCA_RS;
        alu_op_c = dec.alu_op;
      end
      S_EXE_I: begin
        src_a_c  = SRCA_RS;
        src_b_c  = SRCB_IMM;
        ext_c    = ~dec.zext;
        alu_op_c = dec.alu_op;
      end
      S_ALU_WB: begin
        reg_write_c = ~ovf_q;
        reg_dst_c   = dec.r_alu ? RD_RD : RD_RT;
      end
      S_MEM_ADDR: begin
        src_a_c  = SRCA_RS;
        src_b_c  = SRCB_IMM;
        ext_c    = 1'b1;
        alu_op_c = ALU_ADDU;
      end
      S_MEM_RD: begin
        mem_read_c = 1'b1;
        iord_c     = 1'b1;
      end
      S_MEM_LDWB: begin
        reg_write_c = 1'b1;
        wd_c        = WD_MDR;
      end
      S_MEM_WR: begin
        mem_write_c = 1'b1;
        iord_c      = 1'b1;
      end
      S_BRANCH: begin
        src_a_c    = SRCA_RS;
        alu_op_c   = (dec.bgez | dec.bltz) ? ALU_SUBZ : ALU_SUBU;
        npc_c      = NPC_ALUOUT;
        pc_write_c = br_taken;
      end
      S_JUMP: begin
        pc_write_c  = 1'b1;
        npc_c       = (dec.jr | dec.jalr) ? NPC_RS : NPC_JUMP;
        // PC already holds PC+4, which is the link value.
        reg_write_c = dec.jal | dec.jalr;
        reg_dst_c   = dec.jal ? RD_RA : RD_RD;
        wd_c        = WD_PC;
      end
      S_TRAP: exc_c = 1'b1;
      default: ;
    endcase
  end

  // While reset is held the state reads FETCH, but no strobe may fire; the
  // first real fetch happens on the first edge after release.
  assign bus.pc_write  = rstn & pc_write_c;
  assign bus.ir_write  = rstn & ir_write_c;
  assign bus.mem_read  = rstn & mem_read_c;
  assign bus.mem_write = rstn & mem_write_c;
  assign bus.reg_write = rstn & reg_write_c;
  assign bus.exc       = rstn & exc_c;
  assign bus.iord_sel  = iord_c;
  assign bus.ext_op    = ext_c;
  assign bus.reg_dst   = reg_dst_c;
  assign bus.wd_sel    = wd_c;
  assign bus.alu_src_a = src_a_c;
  assign bus.alu_src_b = src_b_c;
  assign bus.npc_sel   = npc_c;
  assign bus.alu_op    = alu_op_c;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl. Two controllers share the stimulus: dut0 with
// overflow trapping enabled, dut1 with it disabled.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mc_ctrl_if if0();
  mc_ctrl_if if1();

  mc_ctrl #(.EXC_ON_OVF(1'b1)) dut0 (.clk(clk), .rstn(rstn), .bus(if0.master));
  mc_ctrl #(.EXC_ON_OVF(1'b0)) dut1 (.clk(clk), .rstn(rstn), .bus(if1.master));

  typedef struct packed {
    logic [3:0] st;
    logic       pw, iw, mr, mw, rw, ex, iord;
    logic [1:0] rdst, wd, sa, sb;
    logic       ext;
    logic [4:0] alu;
    logic [1:0] npc;
  } obs_t;

  typedef struct {
    int    which;
    string tag;
    obs_t  val;
    obs_t  mask;
  } exp_t;

  obs_t o0, o1;
  assign o0 = {if0.state, if0.pc_write, if0.ir_write, if0.mem_read, if0.mem_write,
               if0.reg_write, if0.exc, if0.iord_sel, if0.reg_dst, if0.wd_sel,
               if0.alu_src_a, if0.alu_src_b, if0.ext_op, if0.alu_op, if0.npc_sel};
  assign o1 = {if1.state, if1.pc_write, if1.ir_write, if1.mem_read, if1.mem_write,
               if1.reg_write, if1.exc, if1.iord_sel, if1.reg_dst, if1.wd_sel,
               if1.alu_src_a, if1.alu_src_b, if1.ext_op, if1.alu_op, if1.npc_sel};

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   failures = 0;

  // State and all six strobes are always checked.
  task automatic want(int which, string tag, state_t st,
                      logic pw, logic iw, logic mr, logic mw, logic rw, logic ex);
    cur.which = which;
    cur.tag   = tag;
    cur.val   = '0;
    cur.mask  = '0;
    cur.val.st = st;  cur.val.pw = pw; cur.val.iw = iw; cur.val.mr = mr;
    cur.val.mw = mw;  cur.val.rw = rw; cur.val.ex = ex;
    cur.mask.st = '1; cur.mask.pw = 1'b1; cur.mask.iw = 1'b1; cur.mask.mr = 1'b1;
    cur.mask.mw = 1'b1; cur.mask.rw = 1'b1; cur.mask.ex = 1'b1;
  endtask

  // Optional select checks; a negative argument means "don't care".
  task automatic sel(int iord, int rdst, int wd, int sa, int sb, int ext, int alu, int npc);
    if (iord >= 0) begin cur.val.iord = iord[0];   cur.mask.iord = 1'b1; end
    if (rdst >= 0) begin cur.val.rdst = rdst[1:0]; cur.mask.rdst = '1;   end
    if (wd   >= 0) begin cur.val.wd   = wd[1:0];   cur.mask.wd   = '1;   end
    if (sa   >= 0) begin cur.val.sa   = sa[1:0];   cur.mask.sa   = '1;   end
    if (sb   >= 0) begin cur.val.sb   = sb[1:0];   cur.mask.sb   = '1;   end
    if (ext  >= 0) begin cur.val.ext  = ext[0];    cur.mask.ext  = 1'b1; end
    if (alu  >= 0) begin cur.val.alu  = alu[4:0];  cur.mask.alu  = '1;   end
    if (npc  >= 0) begin cur.val.npc  = npc[1:0];  cur.mask.npc  = '1;   end
  endtask

  task automatic push();
    q.push_back(cur);
  endtask

  task automatic check_now();
    while (q.size() > 0) begin
      exp_t e;
      obs_t o;
      e = q.pop_front();
      o = (e.which == 0) ? o0 : o1;
      checks++;
      assert ((o & e.mask) === (e.val & e.mask)) else begin
        failures++;
        $error("FAIL %s: observed=%h expected=%h mask=%h", e.tag,
               o & e.mask, e.val & e.mask, e.mask);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(logic [5:0] op, logic [5:0] funct, logic [4:0] rt,
                        logic z, logic g, logic v);
    if0.op_i = op; if0.funct_i = funct; if0.rt_i = rt;
    if0.zero_i = z; if0.gez_i = g; if0.ovf_i = v;
    if1.op_i = op; if1.funct_i = funct; if1.rt_i = rt;
    if1.zero_i = z; if1.gez_i = g; if1.ovf_i = v;
  endtask

  task automatic fetch_dec(string t);
    want(0, {t, "/fetch"}, S_FETCH, 1, 1, 1, 0, 0, 0);
    sel(0, -1, -1, 0, 1, -1, ALU_ADDU, 0); push(); cyc();
    want(0, {t, "/decode"}, S_DECODE, 0, 0, 0, 0, 0, 0);
    sel(-1, -1, -1, 0, 3, 1, ALU_ADDU, -1); push(); cyc();
  endtask

  initial begin
    set_in(6'h00, 6'h20, 5'd0, 0, 0, 0);
    @(posedge clk); #1;
    want(0, "reset0", S_FETCH, 0, 0, 0, 0, 0, 0); push();
    want(1, "reset1", S_FETCH, 0, 0, 0, 0, 0, 0); push();
    cyc();
    rstn = 1'b1;

    // add, no overflow
    fetch_dec("add");
    want(0, "add/exe", S_EXE_R, 0, 0, 0, 0, 0, 0); sel(-1, -1, -1, 1, 0, -1, ALU_ADD, -1); push(); cyc();
    want(0, "add/wb", S_ALU_WB, 0, 0, 0, 0, 1, 0); sel(-1, 1, 0, -1, -1, -1, -1, -1); push(); cyc();

    // ori: zero-extended immediate, writes rt
    set_in(6'h0D, 6'h00, 5'd0, 0, 0, 0);
    fetch_dec("ori");
    want(0, "ori/exe", S_EXE_I, 0, 0, 0, 0, 0, 0); sel(-1, -1, -1, 1, 2, 0, ALU_OR, -1); push(); cyc();
    want(0, "ori/wb", S_ALU_WB, 0, 0, 0, 0, 1, 0); sel(-1, 0, 0, -1, -1, -1, -1, -1); push(); cyc();

    // sll: A from shamt
    set_in(6'h00, 6'h00, 5'd0, 0, 0, 0);
    fetch_dec("sll");
    want(0, "sll/exe", S_EXE_R, 0, 0, 0, 0, 0, 0); sel(-1, -1, -1, 2, 0, -1, ALU_SLL, -1); push(); cyc();
    want(0, "sll/wb", S_ALU_WB, 0, 0, 0, 0, 1, 0); push(); cyc();

    // add with overflow: dut0 traps, dut1 writes back
    set_in(6'h00, 6'h20, 5'd0, 0, 0, 0);
    fetch_dec("ovf");
    set_in(6'h00, 6'h20, 5'd0, 0, 0, 1);
    want(0, "ovf/exe0", S_EXE_R, 0, 0, 0, 0, 0, 0); push();
    want(1, "ovf/exe1", S_EXE_R, 0, 0, 0, 0, 0, 0); push(); cyc();
    set_in(6'h00, 6'h20, 5'd0, 0, 0, 0);
    want(0, "ovf/wb0", S_ALU_WB, 0, 0, 0, 0, 0, 0); push();
    want(1, "ovf/wb1", S_ALU_WB, 0, 0, 0, 0, 1, 0); push(); cyc();
    want(0, "ovf/trap0", S_TRAP, 0, 0, 0, 0, 0, 1); push();
    want(1, "ovf/next1", S_FETCH, 1, 1, 1, 0, 0, 0); push(); cyc();

    // next add on dut0: overflow flag must have been cleared
    fetch_dec("add2");
    want(0, "add2/exe", S_EXE_R, 0, 0, 0, 0, 0, 0); push(); cyc();
    want(0, "add2/wb", S_ALU_WB, 0, 0, 0, 0, 1, 0); push(); cyc();

    // lw
    set_in(6'h23, 6'h00, 5'd0, 0, 0, 0);
    fetch_dec("lw");
    want(0, "lw/addr", S_MEM_ADDR, 0, 0, 0, 0, 0, 0); sel(-1, -1, -1, 1, 2, 1, ALU_ADDU, -1); push(); cyc();
    want(0, "lw/rd", S_MEM_RD, 0, 0, 1, 0, 0, 0); sel(1, -1, -1, -1, -1, -1, -1, -1); push(); cyc();
    want(0, "lw/wb", S_MEM_LDWB, 0, 0, 0, 0, 1, 0); sel(-1, 0, 1, -1, -1, -1, -1, -1); push(); cyc();

    // sw
    set_in(6'h2B, 6'h00, 5'd0, 0, 0, 0);
    fetch_dec("sw");
    want(0, "sw/addr", S_MEM_ADDR, 0, 0, 0, 0, 0, 0); push(); cyc();
    want(0, "sw/wr", S_MEM_WR, 0, 0, 0, 1, 0, 0); sel(1, -1, -1, -1, -1, -1, -1, -1); push(); cyc();

    // branches
    set_in(6'h04, 6'h00, 5'd0, 1, 0, 0);
    fetch_dec("beq");
    want(0, "beq/taken", S_BRANCH, 1, 0, 0, 0, 0, 0); sel(-1, -1, -1, 1, 0, -1, ALU_SUBU, 1); push(); cyc();

    set_in(6'h05, 6'h00, 5'd0, 1, 0, 0);
    fetch_dec("bne");
    want(0, "bne/not", S_BRANCH, 0, 0, 0, 0, 0, 0); sel(-1, -1, -1, -1, -1, -1, -1, 1); push(); cyc();

    set_in(6'h01, 6'h00, 5'd0, 0, 0, 0);
    fetch_dec("bltz");
    want(0, "bltz/taken", S_BRANCH, 1, 0, 0, 0, 0, 0); sel(-1, -1, -1, 1, -1, -1, ALU_SUBZ, 1); push(); cyc();

    set_in(6'h01, 6'h00, 5'd1, 0, 0, 0);
    fetch_dec("bgez");
    want(0, "bgez/not", S_BRANCH, 0, 0, 0, 0, 0, 0); sel(-1, -1, -1, -1, -1, -1, ALU_SUBZ, -1); push(); cyc();

    // jumps
    set_in(6'h03, 6'h00, 5'd0, 0, 0, 0);
    fetch_dec("jal");
    want(0, "jal/jump", S_JUMP, 1, 0, 0, 0, 1, 0); sel(-1, 2, 2, -1, -1, -1, -1, 2); push(); cyc();

    set_in(6'h00, 6'h08, 5'd0, 0, 0, 0);
    fetch_dec("jr");
    want(0, "jr/jump", S_JUMP, 1, 0, 0, 0, 0, 0); sel(-1, -1, -1, -1, -1, -1, -1, 3); push(); cyc();

    // illegal opcode
    set_in(6'h3F, 6'h00, 5'd0, 0, 0, 0);
    fetch_dec("ill");
    want(0, "ill/trap", S_TRAP, 0, 0, 0, 0, 0, 1); push(); cyc();

    // reset in the middle of lw
    set_in(6'h23, 6'h00, 5'd0, 0, 0, 0);
    fetch_dec("rlw");
    want(0, "rlw/addr", S_MEM_ADDR, 0, 0, 0, 0, 0, 0); push(); cyc();
    want(0, "rlw/rd", S_MEM_RD, 0, 0, 1, 0, 0, 0); push(); check_now();
    #1 rstn = 1'b0;
    #1;
    want(0, "rlw/async", S_FETCH, 0, 0, 0, 0, 0, 0); push(); check_now();
    @(posedge clk); #1;
    want(0, "rlw/held", S_FETCH, 0, 0, 0, 0, 0, 0); push(); cyc();
    rstn = 1'b1;
    want(0, "rlw/refetch", S_FETCH, 1, 1, 1, 0, 0, 0); push(); cyc();
    want(0, "rlw/redecode", S_DECODE, 0, 0, 0, 0, 0, 0); push(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller for the multi-cycle CPU datapath. Sequences each instruction through fetch/decode/execute/memory/writeback states. Drives every datapath select, the register-file and memory enables, and the 5-bit `ALUOp` into the ALU. Consumes the ALU's `Zero`, `Gez` and `Overflow` flags to resolve branches and trap on signed overflow.

## Interface

Parameters:
- `EXC_ON_OVF`, default 1: 1 = signed overflow on add/sub/addi suppresses writeback and traps; 0 = writeback proceeds.

Ports. Clock/reset are fixed: one clock; reset is asynchronous and active-low.
- `clk` in 1: clock, rising edge.
- `rstn` in 1: asynchronous active-low reset.
- `op_i` in 6: IR[31:26].
- `funct_i` in 6: IR[5:0].
- `rt_i` in 5: IR[20:16], REGIMM select.
- `zero_i`, `gez_i`, `ovf_i` in 1 each: ALU flags, combinational, current cycle.
- `pc_write` out 1: PC load enable.
- `ir_write` out 1: IR load enable.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `reg_write` out 1: register-file write strobe.
- `iord_sel` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `reg_dst` out 2: write register; 0 = rt, 1 = rd, 2 = $31.
- `wd_sel` out 2: write data; 0 = ALUOut, 1 = MDR, 2 = PC.
- `alu_src_a` out 2: 0 = PC, 1 = rs, 2 = shamt.
- `alu_src_b` out 2: 0 = rt, 1 = const 4, 2 = ext imm, 3 = ext imm<<2.
- `ext_op` out 1: 1 = sign-extend, 0 = zero-extend.
- `alu_op` out 5: ALU operation code (`ALU_*` macros).
- `npc_sel` out 2: next PC; 0 = ALU C, 1 = ALUOut, 2 = {PC[31:28], IR[25:0], 2'b00}, 3 = rs.
- `exc` out 1: one-cycle trap pulse.
- `state` out 4: current state, for debug.

## Operation

- States: FETCH, DECODE, EXE_R, EXE_I, MEM_ADDR, MEM_RD, MEM_LDWB, MEM_WR, ALU_WB, BRANCH, JUMP, TRAP.
- FETCH:
  - `mem_read`=`ir_write`=`pc_write`=1, `iord_sel`=0.
  - ALU computes PC+4: `alu_src_a`=0, `alu_src_b`=1, `alu_op`=ALU_ADDU, `npc_sel`=0.
  - Next state: DECODE.
- DECODE:
  - Branch target into ALUOut: `alu_src_a`=0, `alu_src_b`=3, `ext_op`=1, ALU_ADDU.
  - Next state by class:
    - R-ALU → EXE_R.
    - I-ALU → EXE_I.
    - lw/sw → MEM_ADDR.
    - beq/bne/bgez/bltz → BRANCH.
    - j/jal/jr/jalr → JUMP.
    - Anything else → TRAP.
- EXE_R:
  - `alu_src_a`=2 for sll/srl/sra, else 1; `alu_src_b`=0.
  - `alu_op` from funct: add/addu/sub/subu/and/or/xor/nor/slt/sltu/sll(v)/srl(v)/sra(v).
- EXE_I:
  - `alu_src_a`=1, `alu_src_b`=2.
  - `ext_op`=0 for andi/ori/xori, else 1.
  - `alu_op`: addi→ADD, addiu→ADDU, andi, ori, xori, lui, slti→SLT, sltiu→SLTU.
- Overflow:
  - In EXE_R/EXE_I, `ovf_q` <= `ovf_i` & (op is add/sub/addi) & `EXC_ON_OVF`.
  - `ovf_q` is cleared in FETCH.
- ALU_WB:
  - If !`ovf_q`: `reg_write`=1, `wd_sel`=0, `reg_dst`=1 (R) or 0 (I); next state FETCH.
  - If `ovf_q`: `reg_write`=0; next state TRAP.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=2, `ext_op`=1, ALU_ADDU. Next state MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: `mem_read`=1, `iord_sel`=1. Next state MEM_LDWB.
- MEM_LDWB: `reg_write`=1, `wd_sel`=1, `reg_dst`=0. Next state FETCH.
- MEM_WR: `mem_write`=1, `iord_sel`=1. Next state FETCH.
- BRANCH:
  - beq/bne: `alu_src_a`=1, `alu_src_b`=0, ALU_SUBU.
  - bgez/bltz: `alu_src_a`=1, ALU_SUBZ. Op 000001; rt=1 → bgez, rt=0 → bltz; other rt → TRAP from DECODE.
  - `npc_sel`=1.
  - `pc_write` = beq&`zero_i` | bne&!`zero_i` | bgez&`gez_i` | bltz&!`gez_i`. This is the only Mealy output.
  - Next state FETCH.
- JUMP:
  - `pc_write`=1; `npc_sel`=2 for j/jal, 3 for jr/jalr.
  - jal: `reg_write`=1, `reg_dst`=2, `wd_sel`=2.
  - jalr: `reg_write`=1, `reg_dst`=1, `wd_sel`=2. PC still holds PC+4 when written.
  - Next state FETCH.
- TRAP: `exc`=1, all write enables 0. Next state FETCH; PC is already advanced.
- Strobe default: every strobe not listed for a state is 0.

## Timing

- Reset (async, `rstn`=0):
  - `state` = FETCH, `ovf_q` = 0.
  - All strobes and `exc` read 0 while reset is held.
  - First fetch occurs on the first rising edge after deassertion.
- Strobes are Moore-decoded from `state` (plus registered IR fields), except the BRANCH `pc_write`.
- Cycles per instruction:
  - R/I-ALU: 4.
  - lw: 5.
  - sw: 4.
  - branch, jump: 3.
  - illegal or overflow: 3 or 5 respectively, including TRAP.
- Reset asserted mid-instruction aborts immediately; no partial `reg_write` or `mem_write` may be emitted afterward.
- `mem_read` and `mem_write` are never asserted together. `reg_write` and `pc_write` together only in JUMP.

## Structure

- `ctrl_encode_def.v` (shared) holds:
  - `ALU_*` codes.
  - New `STATE_*` encodings.
  - `OP_*` and `FUNCT_*` constants.
  - `NPC_*`, `WD_*` and `RD_*` select constants.
- Sub-module `mc_ctrl_decode`: combinational op/funct/rt → instruction-class one-hots plus EXE `alu_op`.
- `mc_ctrl` holds the state register, `ovf_q` and output decode.

## Test plan

- Reset, then `rstn` high with op=0, funct=0x20 (add), flags 0 → states FETCH,DECODE,EXE_R,ALU_WB; `reg_write`=1 in cycle 4 only, `reg_dst`=1.
- add with `ovf_i`=1 in EXE_R → `reg_write`=0 in ALU_WB; `exc`=1 in cycle 5; FETCH in cycle 6. Repeat with `EXC_ON_OVF`=0 → `reg_write`=1, no `exc`.
- lw (op 0x23) → `mem_read`=1, `iord_sel`=1 in cycle 4; `reg_write`=1, `wd_sel`=1 in cycle 5. sw (0x2B) → `mem_write`=1 in cycle 4, `reg_write` never asserted.
- beq with `zero_i`=1 → `pc_write`=1, `npc_sel`=1 in BRANCH. bne with `zero_i`=1 → `pc_write`=0. bltz (op 1, rt 0) with `gez_i`=0 → `pc_write`=1.
- jal (op 3) → cycle 3: `pc_write`=1, `npc_sel`=2, `reg_write`=1, `reg_dst`=2, `wd_sel`=2. op 0x3F → TRAP in cycle 3, `exc`=1.
- `rstn` pulsed low during MEM_RD → `state`=FETCH asynchronously, `mem_read`=0, no `reg_write` follows.
